// File: rtl/mul1_sequencer_if.sv
// rtl/mul1_sequencer_if.sv - control/handshake bundle between the MUL1 sequencer and its neighbours
interface mul1_sequencer_if #(
  parameter int ADDR_W = 10
);

  // block request from the host
  logic              start;
  logic [ADDR_W:0]   num_samp;

  // sample-memory read port
  logic              z_rd;
  logic [ADDR_W-1:0] z_addr;

  // MUL1 / W register / accumulator control
  logic              en_mul;
  logic              w_load;
  logic              acc_clr;
  logic              zw_valid;
  logic              zw_last;
  logic              acc_ready;

  // status
  logic              busy;
  logic              done;

  // host side: requests blocks and provides accumulator backpressure
  modport master (
    output start, num_samp, acc_ready,
    input  z_rd, z_addr, en_mul, w_load, acc_clr, zw_valid, zw_last, busy, done
  );

  // sequencer side
  modport slave (
    input  start, num_samp, acc_ready,
    output z_rd, z_addr, en_mul, w_load, acc_clr, zw_valid, zw_last, busy, done
  );

endinterface

// File: rtl/mul1_sequencer.sv
// rtl/mul1_sequencer.sv - sequences sample reads through MUL1 with valid/last tagging and backpressure
module mul1_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic             clk_mul,
  input  logic             rst_mul,
  mul1_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  state_t            state_d;

  logic [ADDR_W:0]   n_reg;      // block length latched on start
  logic [ADDR_W:0]   issued;     // reads issued so far in this block
  logic [ADDR_W-1:0] addr_q;     // next sample-memory address

  // two-stage pipe: v1 = memory data at MUL1 inputs, v2 = MUL1 output registers
  logic              v1;
  logic              v2;
  logic              l1;
  logic              l2;

  logic              adv;
  logic              issue;
  logic              last_issue;
  logic              drained;
  logic              accept_start;

  logic              w_load_c;
  logic              acc_clr_c;
  logic              done_c;

  // The whole pipe moves only when the output stage is empty or being consumed.
  assign adv          = !v2 || bus.acc_ready;
  assign issue        = (state_q == ST_RUN) && (issued < n_reg) && adv;
  assign last_issue   = (issued == (n_reg - CNT_ONE));
  assign accept_start = (state_q == ST_IDLE) && bus.start;

  // Leave RUN on the edge where the pipe becomes empty, so DONE follows the last beat directly.
  assign drained      = (issued == n_reg) && !v1 && adv;

  // State register
  always_ff @(posedge clk_mul) begin
    if (rst_mul) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    state_d   = state_q;
    w_load_c  = 1'b0;
    acc_clr_c = 1'b0;
    done_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_load_c  = 1'b1;
        acc_clr_c = 1'b1;
        state_d   = (n_reg != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (drained) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Block counters and read address; the address stops at the last sample instead of wrapping
  always_ff @(posedge clk_mul) begin
    if (rst_mul) begin
      n_reg  <= '0;
      issued <= '0;
      addr_q <= '0;
    end else if (accept_start) begin
      n_reg  <= bus.num_samp;
      issued <= '0;
      addr_q <= '0;
    end else if (issue) begin
      issued <= issued + CNT_ONE;
      if (!last_issue) begin
        addr_q <= addr_q + ADDR_ONE;
      end
    end
  end

  // Pipe valid/last tracking; everything holds while the accumulator stalls a valid output
  always_ff @(posedge clk_mul) begin
    if (rst_mul) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      l1 <= 1'b0;
      l2 <= 1'b0;
    end else if (adv) begin
      v2 <= v1;
      l2 <= l1;
      v1 <= issue;
      l1 <= issue && last_issue;
    end
  end

  assign bus.z_rd     = issue;
  assign bus.z_addr   = addr_q;
  assign bus.en_mul   = v1 && adv;
  assign bus.w_load   = w_load_c;
  assign bus.acc_clr  = acc_clr_c;
  assign bus.zw_valid = v2;
  assign bus.zw_last  = v2 && l2;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_c;

endmodule

// File: doc/mul1_sequencer.md
# mul1_sequencer

Controller that sequences the MUL1 outer-product stage of the FastICA one-unit datapath over a block of whitened samples. On `start` it latches the sample count, strobes the W register load and the downstream accumulator clear, then streams sample vectors z from the sample memory into MUL1, one per cycle. It drives MUL1's `en_mul` and tags MUL1's registered zw outputs with valid/last flags for the accumulator. It stalls the whole pipe under accumulator backpressure.

## Interface
- `ADDR_W`, 10, sample-memory address width; max block length 2^ADDR_W
- `clk_mul`  in  1  single clock, shared with MUL1 and the sample memory
- `rst_mul`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a block; sampled only in IDLE
- `num_samp`  in  ADDR_W+1  samples in block, 0..2^ADDR_W; latched on accepted `start`
- `z_rd`  out  1  sample-memory read enable; memory returns z1..z4 to MUL1 one cycle later and holds its output while `z_rd`=0
- `z_addr`  out  ADDR_W  sample-memory read address
- `en_mul`  out  1  MUL1 enable
- `w_load`  out  1  one-cycle pulse; W register captures new w11..w44; W is stable until next `w_load`
- `acc_clr`  out  1  one-cycle pulse; clears downstream accumulator
- `zw_valid`  out  1  MUL1 zw outputs hold the product of one sample
- `zw_last`  out  1  qualifies `zw_valid`; marks the final sample of the block
- `acc_ready`  in  1  accumulator accepts zw this cycle
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at block completion

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: `start`=1 -> LOAD; latch `num_samp` into `n_reg`; clear `issued` to 0.
  - LOAD: one cycle. `w_load`=1, `acc_clr`=1. Goes to RUN if `n_reg`!=0, otherwise to DONE.
  - RUN: issue reads and track the pipe. Goes to DONE when `issued`==`n_reg` and both pipe valid bits are 0.
  - DONE: one cycle. `done`=1, then -> IDLE.
- Pipe uses two valid bits:
  - `v1`: memory data is present at the MUL1 z inputs.
  - `v2`: MUL1 output registers are valid; drives `zw_valid`.
  - Last tags `l1` and `l2` travel with `v1` and `v2`.
- `adv` = !v2 | acc_ready.
- `issue` = (state==RUN) & (issued<n_reg) & adv.
  - `z_rd` = issue.
  - On issue, `z_addr` increments and `issued` increments.
  - `l1` is set when issued==n_reg-1.
- `en_mul` = v1 & adv.
- On `adv`: `v2`<=`v1`, `l2`<=`l1`, `v1`<=`issue`. When `adv`=0, all pipe state holds. MUL1 then holds its registers because `en_mul`=0, and the memory holds its output because `z_rd`=0.
- `zw_last` = v2 & l2.
- `z_addr` resets to 0 on entry to LOAD. It is not wrapped; it reaches at most 2^ADDR_W-1.
- `start` during busy is ignored. `num_samp` changes during busy have no effect.
- `acc_ready` is don't-care when `zw_valid`=0.
- `rst_mul` in any state: at the next edge, state=IDLE, `v1`=`v2`=0, counters 0, all outputs 0. The partial block is abandoned and no `done` is produced.

## Timing
- Reset values: every output is 0 (`z_addr`=0, `busy`=0, `done`=0, `zw_valid`=0).
- `start` is sampled at edge T; LOAD is active in cycle T+1.
- With `acc_ready` held at 1:
  - first `z_rd` at T+2
  - first `en_mul` at T+3
  - sample k has `zw_valid` at T+4+k
  - `zw_last` at T+3+N
  - `done` at T+4+N
  - `busy` high from T+1 through T+4+N
- Throughput is 1 sample/cycle.
- Each `acc_ready`=0 cycle while `zw_valid`=1 delays all subsequent events by one cycle. The `zw` value and `zw_last` stay unchanged during the stall.
- `num_samp`=0: LOAD at T+1, `done` at T+2, no `z_rd`, `en_mul` or `zw_valid`.
- `start` held high through a block re-triggers on the cycle after DONE (IDLE).

## Test plan
- Nominal: `num_samp`=4, `acc_ready`=1. Required response:
  - `w_load`/`acc_clr` at T+1
  - `z_addr` 0,1,2,3 at T+2..T+5
  - `zw_valid` T+4..T+7; each zw equals the MUL1 product for the matching address
  - `zw_last` only at T+7
  - `done` at T+8
- Backpressure: `num_samp`=3, `acc_ready`=0 in the cycle sample 1 is valid. Required response:
  - sample 1 zw held for 2 cycles
  - `en_mul`=0 and `z_rd`=0 during the stall
  - no sample lost or duplicated
  - `done` one cycle later than nominal
- Empty block: `num_samp`=0 -> `busy` for exactly 2 cycles; `done` at T+2; `zw_valid` never 1.
- Full block: `num_samp`=2^ADDR_W -> last address 2^ADDR_W-1; exactly 2^ADDR_W `zw_valid` beats; `zw_last` on the final beat.
- Reset mid-block: `rst_mul` asserted while sample 2 of 8 is in flight -> next cycle all outputs 0 and no `done`. A following `start` with `num_samp`=2 runs cleanly from address 0.
- Ignored start: pulse `start` with a different `num_samp` during RUN -> block length unchanged; exactly one `done`.
